// File: rtl/dii_package.sv
// DII link flit format shared by every debug module and arbiter on a tile.
package dii_package;

    typedef struct packed {
        logic        valid;
        logic        last;
        logic [15:0] data;
    } dii_flit;

endpackage

// File: rtl/osd_rr_pick.sv
// Combinational round-robin pick: rotates the request vector so the slot after
// last_grant sits at bit 0, then takes the lowest set bit.
module osd_rr_pick #(
    parameter int N     = 4,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] last_grant,
    output logic [PTR_W-1:0] pick,
    output logic             any
);

    logic [2*N-1:0] req_dbl;
    logic [N-1:0]   req_rot;
    int             start;

    assign req_dbl = {req, req};

    always_comb begin
        // NOTE: every output of a combinational block gets a default before any branch, otherwise a latch is inferred.
        pick  = '0;
        any   = 1'b0;
        // Explicit wrap keeps the start index below N for non-power-of-two N.
        start = (int'(last_grant) >= N - 1) ? 0 : int'(last_grant) + 1;
        req_rot = N'(req_dbl >> start);
        for (int i = 0; i < N; i++) begin
            if (!any && req_rot[i]) begin
                any  = 1'b1;
                pick = PTR_W'((start + i) % N);
            end
        end
    end

endmodule

// File: rtl/osd_dii_arbiter_rr.sv
// Packet-atomic round-robin arbiter merging N DII debug_out streams onto one
// router injection port through a single registered output stage.
module osd_dii_arbiter_rr
    import dii_package::*;
#(
    parameter int N     = 4,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  dii_flit          in_flit [N],
    output logic [N-1:0]     in_ready,
    output dii_flit          out_flit,
    input  logic             out_ready,
    output logic [PTR_W-1:0] grant_idx,
    output logic             busy
);

    typedef enum logic {IDLE, LOCK} state_e;

    state_e           state_q, state_d;
    logic [PTR_W-1:0] grant_idx_q, grant_idx_d;
    logic [PTR_W-1:0] last_grant_q, last_grant_d;
    logic             busy_q, busy_d;
    dii_flit          out_q, out_d;

    logic [N-1:0]     req;
    logic [PTR_W-1:0] pick;
    logic             any;
    logic             can_load;
    dii_flit          owner_flit;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            req[i] = in_flit[i].valid;
        end
    end

    osd_rr_pick #(.N(N), .PTR_W(PTR_W)) u_pick (
        .req        (req),
        .last_grant (last_grant_q),
        .pick       (pick),
        .any        (any)
    );

    assign owner_flit = in_flit[grant_idx_q];
    // Accept and drain can overlap, so the single register still runs at full rate.
    assign can_load   = !out_q.valid || out_ready;

    always_comb begin
        state_d      = state_q;
        grant_idx_d  = grant_idx_q;
        last_grant_d = last_grant_q;
        busy_d       = busy_q;
        out_d        = out_q;
        in_ready     = '0;

        if (out_ready) begin
            out_d.valid = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (any) begin
                    grant_idx_d  = pick;
                    last_grant_d = pick;
                    state_d      = LOCK;
                    busy_d       = 1'b1;
                end
            end
            LOCK: begin
                // No timeout: DII has no abort, so a stalled owner keeps the link.
                in_ready[grant_idx_q] = can_load;
                if (owner_flit.valid && can_load) begin
                    out_d       = owner_flit;
                    out_d.valid = 1'b1;
                    if (owner_flit.last) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            grant_idx_q  <= '0;
            last_grant_q <= PTR_W'(N - 1);
            busy_q       <= 1'b0;
            // NOTE: the data field is reset too so the link never shows stale bits after reset.
            out_q        <= '0;
        end else begin
            state_q      <= state_d;
            grant_idx_q  <= grant_idx_d;
            last_grant_q <= last_grant_d;
            busy_q       <= busy_d;
            out_q        <= out_d;
        end
    end

    assign out_flit  = out_q;
    assign grant_idx = grant_idx_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_osd_dii_arbiter_rr.sv
// Directed bench for osd_dii_arbiter_rr: an N=4 instance for most scenarios and
// an N=3 instance for pointer wrap with a non-power-of-two requester count.
module tb_osd_dii_arbiter_rr;
    import dii_package::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    dii_flit    in_flit [4];
    logic [3:0] in_ready;
    dii_flit    out_flit;
    logic       out_ready;
    logic [1:0] grant_idx;
    logic       busy;

    dii_flit    in3 [3];
    logic [2:0] in_ready3;
    dii_flit    out3;
    logic       out_ready3;
    logic [1:0] grant3;
    logic       busy3;

    int errors = 0;
    int checks = 0;

    logic [3:0] src_en, src_stall;
    int         src_len;
    int         src_cnt [4];
    int         src_pkt [4];

    osd_dii_arbiter_rr #(.N(4)) dut4 (
        .clk(clk), .rst(rst), .in_flit(in_flit), .in_ready(in_ready),
        .out_flit(out_flit), .out_ready(out_ready), .grant_idx(grant_idx), .busy(busy)
    );

    osd_dii_arbiter_rr #(.N(3)) dut3 (
        .clk(clk), .rst(rst), .in_flit(in3), .in_ready(in_ready3),
        .out_flit(out3), .out_ready(out_ready3), .grant_idx(grant3), .busy(busy3)
    );

    function automatic logic [15:0] tag(int s, int p, int c);
        return 16'((s << 12) | ((p & 15) << 8) | (c & 255));
    endfunction

    function automatic dii_flit mk(logic v, logic l, logic [15:0] d);
        dii_flit f;
        f.valid = v;
        f.last  = l;
        f.data  = d;
        return f;
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_srcs;
        for (int i = 0; i < 4; i++) begin
            in_flit[i] = mk(src_en[i] && !src_stall[i], src_cnt[i] == src_len - 1,
                            tag(i, src_pkt[i], src_cnt[i]));
        end
    endtask

    // Source side: a flit leaves a requester when valid && ready at the edge.
    task automatic advance;
        logic [3:0] fire;
        for (int i = 0; i < 4; i++) fire[i] = in_ready[i] && in_flit[i].valid;
        step();
        for (int i = 0; i < 4; i++) begin
            if (fire[i]) begin
                if (src_cnt[i] == src_len - 1) begin
                    src_cnt[i] = 0;
                    src_pkt[i]++;
                end else begin
                    src_cnt[i]++;
                end
            end
        end
        drive_srcs();
    endtask

    task automatic do_reset;
        rst       = 1'b0;
        src_en    = '0;
        src_stall = '0;
        src_len   = 1;
        for (int i = 0; i < 4; i++) begin
            src_cnt[i] = 0;
            src_pkt[i] = 0;
        end
        drive_srcs();
        for (int i = 0; i < 3; i++) in3[i] = mk(1'b0, 1'b0, 16'h0);
        out_ready  = 1'b1;
        out_ready3 = 1'b1;
        step();
        step();
        rst = 1'b1;
    endtask

    task automatic test_reset;
        do_reset();
        rst = 1'b0;
        step();
        checks++; if (out_flit !== mk(1'b0, 1'b0, 16'h0)) begin errors++; $display("FAIL reset_out_flit: got %h expected 0", out_flit); end
        checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL reset_in_ready: got %b expected 0000", in_ready); end
        checks++; if (grant_idx !== 2'd0) begin errors++; $display("FAIL reset_grant_idx: got %0d expected 0", grant_idx); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (out3 !== mk(1'b0, 1'b0, 16'h0) || busy3 !== 1'b0 || in_ready3 !== 3'b000)
            begin errors++; $display("FAIL reset_n3: got out=%h busy=%b rdy=%b expected 0/0/000", out3, busy3, in_ready3); end
        rst = 1'b1;
        step();
        checks++; if (busy !== 1'b0 || in_ready !== 4'b0000) begin errors++; $display("FAIL idle_no_req: got busy=%b rdy=%b expected 0/0000", busy, in_ready); end
    endtask

    task automatic test_single;
        do_reset();
        in_flit[2] = mk(1'b1, 1'b0, 16'h1111);
        #1;
        checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL single_idle_ready: got %b expected 0000", in_ready); end
        step();
        checks++; if (grant_idx !== 2'd2 || busy !== 1'b1) begin errors++; $display("FAIL single_grant: got idx=%0d busy=%b expected 2/1", grant_idx, busy); end
        checks++; if (in_ready !== 4'b0100 || out_flit.valid !== 1'b0) begin errors++; $display("FAIL single_t1: got rdy=%b v=%b expected 0100/0", in_ready, out_flit.valid); end
        step();
        checks++; if (out_flit !== mk(1'b1, 1'b0, 16'h1111)) begin errors++; $display("FAIL single_flit0: got %h expected 1111 valid", out_flit); end
        in_flit[2] = mk(1'b1, 1'b0, 16'h2222);
        step();
        checks++; if (out_flit !== mk(1'b1, 1'b0, 16'h2222)) begin errors++; $display("FAIL single_flit1: got %h expected 2222 valid", out_flit); end
        in_flit[2] = mk(1'b1, 1'b1, 16'h3333);
        step();
        checks++; if (out_flit !== mk(1'b1, 1'b1, 16'h3333)) begin errors++; $display("FAIL single_flit2: got %h expected 3333 valid last", out_flit); end
        checks++; if (busy !== 1'b0 || in_ready !== 4'b0000) begin errors++; $display("FAIL single_release: got busy=%b rdy=%b expected 0/0000", busy, in_ready); end
        in_flit[2] = mk(1'b0, 1'b0, 16'h0);
        step();
        checks++; if (out_flit.valid !== 1'b0) begin errors++; $display("FAIL single_drained: got v=%b expected 0", out_flit.valid); end
    endtask

    // Continuous 2-flit packets from all four: each packet takes IDLE, LOCK, LOCK.
    task automatic test_fairness;
        dii_flit exp;
        int k, ph, o, pk;
        do_reset();
        src_en  = 4'b1111;
        src_len = 2;
        drive_srcs();
        for (int n = 0; n < 24; n++) begin
            k  = n / 3;
            ph = n % 3;
            o  = k % 4;
            pk = k / 4;
            if (ph == 0) begin
                checks++; if (busy !== 1'b0 || in_ready !== 4'b0000) begin errors++; $display("FAIL fair_bubble n=%0d: got busy=%b rdy=%b expected 0/0000", n, busy, in_ready); end
                exp = (n == 0) ? mk(1'b0, 1'b0, 16'h0) : mk(1'b1, 1'b1, tag((k - 1) % 4, (k - 1) / 4, 1));
                checks++; if ((n == 0 && out_flit.valid !== 1'b0) || (n != 0 && out_flit !== exp)) begin errors++; $display("FAIL fair_tail n=%0d: got %h expected %h", n, out_flit, exp); end
            end else if (ph == 1) begin
                checks++; if (grant_idx !== 2'(o) || busy !== 1'b1) begin errors++; $display("FAIL fair_grant n=%0d: got idx=%0d busy=%b expected %0d/1", n, grant_idx, busy, o); end
                checks++; if (in_ready !== 4'(1 << o) || out_flit.valid !== 1'b0) begin errors++; $display("FAIL fair_lock n=%0d: got rdy=%b v=%b expected %b/0", n, in_ready, out_flit.valid, 4'(1 << o)); end
            end else begin
                exp = mk(1'b1, 1'b0, tag(o, pk, 0));
                checks++; if (in_ready !== 4'(1 << o) || out_flit !== exp) begin errors++; $display("FAIL fair_head n=%0d: got rdy=%b out=%h expected %b/%h", n, in_ready, out_flit, 4'(1 << o), exp); end
            end
            advance();
        end
    endtask

    task automatic test_backpressure;
        dii_flit f [6];
        int rx;
        do_reset();
        src_en  = 4'b0010;
        src_len = 6;
        drive_srcs();
        for (int j = 0; j < 6; j++) f[j] = mk(1'b1, j == 5, tag(1, 0, j));
        rx = 0;
        for (int n = 0; n < 40 && rx < 6; n++) begin
            if (src_pkt[1] != 0) begin
                src_en[1] = 1'b0;
                drive_srcs();
            end
            out_ready = (n >= 3 && n <= 7) ? 1'b0 : (n >= 8) ? (n % 2 == 1) : 1'b1;
            #1;
            if (n >= 3 && n <= 7) begin
                checks++; if (out_flit !== f[1] || in_ready !== 4'b0000) begin errors++; $display("FAIL bp_hold n=%0d: got out=%h rdy=%b expected %h/0000", n, out_flit, in_ready, f[1]); end
            end
            if (out_flit.valid && out_ready) begin
                checks++; if (out_flit !== f[rx]) begin errors++; $display("FAIL bp_order #%0d: got %h expected %h", rx, out_flit, f[rx]); end
                rx++;
            end
            advance();
        end
        checks++; if (rx !== 6) begin errors++; $display("FAIL bp_count: got %0d flits expected 6", rx); end
        out_ready = 1'b1;
        step();
        step();
        checks++; if (out_flit.valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL bp_no_dup: got v=%b busy=%b expected 0/0", out_flit.valid, busy); end
    endtask

    task automatic test_owner_stall;
        do_reset();
        src_en  = 4'b0011;
        src_len = 4;
        drive_srcs();
        for (int n = 0; n <= 16; n++) begin
            src_stall[0] = (n >= 3 && n <= 12);
            drive_srcs();
            #1;
            if (n == 1) begin
                checks++; if (grant_idx !== 2'd0 || in_ready !== 4'b0001) begin errors++; $display("FAIL stall_grant: got idx=%0d rdy=%b expected 0/0001", grant_idx, in_ready); end
            end
            if (n >= 3 && n <= 12) begin
                checks++; if (grant_idx !== 2'd0 || busy !== 1'b1 || in_ready !== 4'b0001) begin errors++; $display("FAIL stall_hold n=%0d: got idx=%0d busy=%b rdy=%b expected 0/1/0001", n, grant_idx, busy, in_ready); end
            end
            if (n == 14) begin
                checks++; if (out_flit !== mk(1'b1, 1'b0, tag(0, 0, 2))) begin errors++; $display("FAIL stall_resume: got %h expected %h", out_flit, tag(0, 0, 2)); end
            end
            if (n == 15) begin
                checks++; if (out_flit !== mk(1'b1, 1'b1, tag(0, 0, 3)) || busy !== 1'b0) begin errors++; $display("FAIL stall_done: got out=%h busy=%b expected %h last/0", out_flit, busy, tag(0, 0, 3)); end
            end
            if (n == 16) begin
                checks++; if (grant_idx !== 2'd1 || busy !== 1'b1) begin errors++; $display("FAIL stall_next: got idx=%0d busy=%b expected 1/1", grant_idx, busy); end
            end
            advance();
        end
    endtask

    task automatic test_wrap_n3;
        logic [1:0] g;
        do_reset();
        in3[1] = mk(1'b1, 1'b1, 16'hA001);
        step();
        checks++; if (grant3 !== 2'd1 || in_ready3 !== 3'b010) begin errors++; $display("FAIL n3_grant1: got idx=%0d rdy=%b expected 1/010", grant3, in_ready3); end
        in3[0] = mk(1'b1, 1'b1, 16'hB000);
        in3[2] = mk(1'b1, 1'b1, 16'hB002);
        step();
        checks++; if (busy3 !== 1'b0 || out3 !== mk(1'b1, 1'b1, 16'hA001)) begin errors++; $display("FAIL n3_out1: got busy=%b out=%h expected 0/A001", busy3, out3); end
        in3[1] = mk(1'b0, 1'b0, 16'h0);
        step();
        checks++; if (grant3 !== 2'd2 || in_ready3 !== 3'b100) begin errors++; $display("FAIL n3_grant2: got idx=%0d rdy=%b expected 2/100", grant3, in_ready3); end
        step();
        checks++; if (busy3 !== 1'b0 || out3 !== mk(1'b1, 1'b1, 16'hB002)) begin errors++; $display("FAIL n3_out2: got busy=%b out=%h expected 0/B002", busy3, out3); end
        in3[2] = mk(1'b0, 1'b0, 16'h0);
        step();
        checks++; if (grant3 !== 2'd0 || in_ready3 !== 3'b001) begin errors++; $display("FAIL n3_wrap0: got idx=%0d rdy=%b expected 0/001", grant3, in_ready3); end
        in3[1] = mk(1'b1, 1'b1, 16'hC001);
        in3[2] = mk(1'b1, 1'b1, 16'hC002);
        step();
        for (int k = 0; k < 6; k++) begin
            checks++; if (grant3 >= 2'd3) begin errors++; $display("FAIL n3_range_idle k=%0d: got %0d expected <3", k, grant3); end
            step();
            g = 2'((1 + k) % 3);
            checks++; if (grant3 !== g || in_ready3 !== 3'(1 << g)) begin errors++; $display("FAIL n3_rotate k=%0d: got idx=%0d rdy=%b expected %0d/%b", k, grant3, in_ready3, g, 3'(1 << g)); end
            step();
        end
    endtask

    task automatic test_async_reset;
        do_reset();
        src_en  = 4'b0100;
        src_len = 4;
        drive_srcs();
        advance();
        advance();
        checks++; if (busy !== 1'b1 || out_flit !== mk(1'b1, 1'b0, tag(2, 0, 0))) begin errors++; $display("FAIL areset_pre: got busy=%b out=%h expected 1/%h", busy, out_flit, tag(2, 0, 0)); end
        #2;
        rst = 1'b0;
        #1;
        checks++; if (out_flit !== mk(1'b0, 1'b0, 16'h0) || busy !== 1'b0 || in_ready !== 4'b0000 || grant_idx !== 2'd0)
            begin errors++; $display("FAIL areset_now: got out=%h busy=%b rdy=%b idx=%0d expected 0/0/0000/0", out_flit, busy, in_ready, grant_idx); end
        src_en = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            src_cnt[i] = 0;
            src_pkt[i] = 0;
        end
        drive_srcs();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        step();
        checks++; if (grant_idx !== 2'd0 || busy !== 1'b1 || in_ready !== 4'b0001) begin errors++; $display("FAIL areset_first_pick: got idx=%0d busy=%b rdy=%b expected 0/1/0001", grant_idx, busy, in_ready); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_backpressure();
        test_owner_stall();
        test_wrap_n3();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/osd_dii_arbiter_rr.md
Name: osd_dii_arbiter_rr

Overview:
- Packet-atomic round-robin arbiter that shares one outgoing DII debug link between N trace/debug modules (CTM, STM, MAM, …) on a tile.
- Sits between the modules' debug_out ports and the single ring/router injection port.
- Guarantees that a packet is never interleaved with another, and gives every requester a fair share of the link.
- One registered output stage decouples router backpressure timing from module logic.

Parameters:
- N, 4, number of requesting modules (2..16).
- PTR_W, $clog2(N), width of the grant/pointer index (derived; do not override).

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, asynchronous, active-low (rst=0 resets).
- in_flit  input  dii_flit[N]  per-requester flit {valid, last, data[15:0]}.
- in_ready  output  N  per-requester ready; a flit transfers when in_flit[i].valid && in_ready[i].
- out_flit  output  dii_flit  arbitrated flit toward the router.
- out_ready  input  1  router ready; an output flit transfers when out_flit.valid && out_ready.
- grant_idx  output  PTR_W  index of current owner (debug/observation).
- busy  output  1  a packet is locked through the arbiter.

Behaviour:
- Reset values (async on rst=0): state=IDLE, out_flit.valid=0, out_flit.last=0, out_flit.data=0, in_ready=0, grant_idx=0, busy=0, rr pointer last_grant=N-1, so requester 0 has first priority after reset.
- The FSM has two states, IDLE and LOCK.
- IDLE:
  - in_ready is all zero.
  - If any in_flit[i].valid is set, pick the first valid index found by searching last_grant+1, last_grant+2, … modulo N.
  - On the next edge: grant_idx <= pick, last_grant <= pick, state <= LOCK, busy <= 1.
  - If no request is present, stay in IDLE.
- LOCK:
  - in_ready[grant_idx] = (!out_flit.valid || out_ready).
  - All other in_ready bits are 0.
  - On an input transfer, the output register loads the flit, with out_flit.valid <= 1 on the next edge.
  - If no input transfer happens and out_ready=1, then out_flit.valid <= 0.
  - When the transferring flit has last=1: state <= IDLE and busy <= 0 on that same edge.
- Output register:
  - Single-entry pipeline that sustains full throughput: an accept and a drain may happen in the same cycle.
  - out_flit is held stable while valid && !out_ready.
- Latency:
  - A request first seen valid in IDLE at cycle t is granted at the edge ending t.
  - Its first flit is accepted in cycle t+1 and is visible on out_flit in cycle t+2.
  - There is exactly one bubble cycle (IDLE) between consecutive packets.
- Boundaries:
  - Single-flit packet (valid && last on the first flit): LOCK lasts exactly one accept cycle.
  - Owner deasserts valid mid-packet: the lock is held indefinitely with no timeout, because DII has no abort.
  - A non-owner's valid changing during LOCK is ignored.
  - Pointer wrap-around: a pick at index N-1 makes index 0 highest priority next.
  - N=1 degenerates to pass-through with the bubble and register.
  - Reset mid-packet: the output register is dropped and the FSM returns to IDLE. Packet integrity across reset is not guaranteed.
  - Simultaneous last-accept and new requests: arbitration happens in the following IDLE cycle, using the updated last_grant.
- Width rules: pointer arithmetic is modulo N, including non-power-of-two N such as N=3; indices must never reach N.

Decomposition:
- dii_flit already lives in dii_package; no new typedefs are added.
- Sub-module osd_rr_pick (combinational: req[N], last_grant[PTR_W] → pick[PTR_W], any): a rotate-based priority search, reusable by other osd arbiters.
- The arbiter instantiates it once.

Test Plan:
- Single request: after reset, req 2 sends 3 flits (0x1111, 0x2222, 0x3333 last) with out_ready=1 → grant_idx=2, out_flit sequence matches, first flit at t+2, busy falls after the last flit.
- Fairness: all 4 requesters continuously send 2-flit packets → grant order 0,1,2,3,0,1…, one bubble between packets, no interleaving; check data tags per source.
- Backpressure: out_ready held 0 for 5 cycles mid-packet → out_flit stable, in_ready[owner]=0 while the register is full, no flit lost or duplicated. Then toggle out_ready each cycle and check the order is preserved.
- Owner stall: owner drops valid for 10 cycles mid-packet while req 1 is valid → grant unchanged, in_ready[1]=0 throughout, packet completes afterwards.
- Wrap and N=3: instantiate N=3, requesters 2 and 0 valid after granting 1 → grant 2, then 0. Repeat with 1-flit packets → no index ≥3.
- Async reset mid-packet: assert rst=0 asynchronously between edges while in LOCK with out_flit valid → out_flit.valid=0, busy=0, in_ready=0 immediately. After release, requester 0 wins the first arbitration.
